mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one external RAM port between two bus masters.
- m0 is the CPU data port (ram_read/ram_write, e_addr_bus, e_data, e_mem_busy/e_mem_ready). m1 is a secondary master such as a DMA or video fetcher.
- Sequences each access as a fixed-latency RAM cycle and returns a busy/ready handshake to the requester.
- Picks between simultaneous requests round-robin.

Parameters:
- WAIT_CYCLES, 2, cycles the RAM strobe is held per access; legal range is 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-low reset: sampled on the rising edge, and low means reset.
- m0_read, m0_write  in  1 each  CPU request strobes; held until m0_ready.
- m0_addr  in  16  CPU address.
- m0_wdata  in  16  CPU write data.
- m0_rdata  out  16  CPU read data.
- m0_busy  out  1  CPU stall.
- m0_ready  out  1  CPU completion pulse.
- m1_read, m1_write, m1_addr, m1_wdata, m1_rdata, m1_busy, m1_ready: same set for master 1.
- ram_addr  out  16  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data.
- ram_read, ram_write  out  1 each  RAM strobes.

Behaviour:
- Request: mX_req = mX_read | mX_write. If both are high, the access is a write.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No strobes.
  - When any request is high at the edge: latch grant, op, addr and wdata into internal registers; load cnt=WAIT_CYCLES-1; go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration, applied in IDLE only:
  - If only one master requests, it wins.
  - If both request, the master not in last_grant wins.
  - last_grant updates on every grant.
  - Reset sets last_grant=1, so m0 wins the first contention.
- ACCESS:
  - ram_addr and ram_wdata are driven from the latched registers.
  - ram_read or ram_write follows the latched op, for exactly WAIT_CYCLES cycles.
  - cnt decrements each cycle. At the edge where cnt==0: a read captures ram_rdata into the granted master's rdata register; then go to DONE.
- DONE:
  - Strobes low.
  - mX_ready=1 for the granted master for exactly one cycle.
  - Next state is always IDLE.
- Latency: a request first sampled at edge n gives strobes in cycles n+1..n+WAIT_CYCLES and ready in cycle n+WAIT_CYCLES+1.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Busy: mX_busy = mX_req & ~mX_ready (combinational). It is high from the first request cycle, including while the master waits for arbitration, and low in the ready cycle.
- Requesters must deassert the request in the cycle after ready. If the request is still high at the IDLE edge, it is a new access.
- Read data:
  - mX_rdata is registered.
  - It holds its value until that master's next completed read.
  - It is unchanged by writes and by the other master's accesses.
- Changes to a master's addr/wdata after its grant are ignored, because the values are latched.
- A request withdrawn before grant is simply not served. A request withdrawn after grant still completes, and its ready pulse is still produced.
- Reset values (rst low at an edge, including mid-ACCESS): state=IDLE, cnt=0, ram_read=ram_write=0, ram_addr=ram_wdata=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, last_grant=1. An aborted access gives no ready pulse.
- Out-of-range WAIT_CYCLES (0 or >15) is a configuration error: the design issues a $error at elaboration.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: m0 (CPU) always wins contention and last_grant is not used. m1 can be starved while the CPU issues requests continuously.
- Undefined: round-robin, as described in Behaviour.

Test Plan:
- WAIT_CYCLES=2. After reset, m0_read with addr 0x0040 and RAM returning 0xBEEF:
  - ram_read is high for 2 cycles with ram_addr=0x0040.
  - m0_ready pulses in the 3rd cycle after the request edge.
  - m0_rdata=0xBEEF.
  - m0_busy is high until the ready cycle.
- m1_write with addr 0x1234, data 0xA5A5 → ram_write is high 2 cycles with ram_addr=0x1234 and ram_wdata=0xA5A5; m1_ready pulses; m0_rdata is unchanged.
- Both masters request at the same edge right after reset:
  - m0 is served first while m1_busy stays high.
  - m1 is granted at the IDLE edge following m0's DONE.
  - m1_ready comes 4 cycles after m0_ready.
- Both masters hold requests continuously (each re-asserting after its ready) → grants alternate m0, m1, m0, m1 over 4 accesses. With MEM_ARB_FIXED_PRIO_EN defined, all 4 grants go to m0.
- rst pulled low during the 2nd ACCESS cycle → next cycle all strobes are 0, no ready pulse occurs, and state is IDLE. After rst is released, a held m0_read restarts a full access.
- m0_read and m0_write both high, data 0x00FF → a write is performed (ram_write=1, ram_read=0) and m0_ready pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external RAM port between two bus masters. m0 is the CPU data
//   port; m1 is a secondary master such as a DMA or video fetcher. Each access
//   is a fixed-latency RAM cycle: the strobe is held for WAIT_CYCLES cycles,
//   followed by a one-cycle ready pulse to the granted master.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined   -> m0 always wins contention. m1 can
//                                       starve while m0 requests continuously.
//                          undefined -> round-robin between the two masters.
//
// Parameters:
//   WAIT_CYCLES  number of cycles the RAM strobe is held (1..15)
//
// Ports:
//   clk, rst              system clock; synchronous active-low reset
//   mX_read, mX_write     request strobes, held until mX_ready (both -> write)
//   mX_addr, mX_wdata     request address / write data, latched at grant
//   mX_rdata              registered read data of master X's last completed read
//   mX_busy               stall: request pending and not completing this cycle
//   mX_ready              one-cycle completion pulse
//   ram_addr, ram_wdata   RAM address / write data
//   ram_rdata             RAM read data, captured on the last strobe cycle
//   ram_read, ram_write   RAM strobes
//
// state  | meaning
// IDLE   | no strobes; arbitrate and latch the winning request
// ACCESS | RAM strobe held; cnt counts down to the last strobe cycle
// DONE   | strobes low; ready pulse to the granted master

module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic [15:0] m0_rdata,
    output logic        m0_busy,
    output logic        m0_ready,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic [15:0] m1_rdata,
    output logic        m1_busy,
    output logic        m1_ready,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_read,
    output logic        ram_write
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_arbiter: WAIT_CYCLES=%0d is outside 1..15", WAIT_CYCLES);
    end

    state_t     state;
    logic [3:0] cnt;
    logic       gnt_m1;      // granted master of the current access
    logic       op_write;    // latched operation of the current access
    logic       m0_req;
    logic       m1_req;
    logic       pick_m1;
    logic       pick_write;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic       last_grant;  // 1: m1 was granted last
`endif

    assign m0_req  = m0_read | m0_write;
    assign m1_req  = m1_read | m1_write;
    assign m0_busy = m0_req & ~m0_ready;
    assign m1_busy = m1_req & ~m1_ready;

    always_comb begin
        pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            pick_m1 = 1'b0;
`else
            // Contention goes to the master that was not granted last.
            pick_m1 = ~last_grant;
`endif
        end else begin
            pick_m1 = m1_req;
        end
    end

    // Write wins when read and write are both asserted.
    assign pick_write = pick_m1 ? m1_write : m0_write;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            gnt_m1    <= 1'b0;
            op_write  <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_wdata <= 16'h0000;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            m0_rdata  <= 16'h0000;
            m1_rdata  <= 16'h0000;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    if (m0_req || m1_req) begin
                        gnt_m1    <= pick_m1;
                        op_write  <= pick_write;
                        ram_addr  <= pick_m1 ? m1_addr : m0_addr;
                        ram_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                        ram_read  <= ~pick_write;
                        ram_write <= pick_write;
                        cnt       <= CNT_LOAD;
                        state     <= ACCESS;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_grant <= pick_m1;
`endif
                    end
                end

                ACCESS: begin
                    if (cnt == 4'd0) begin
                        ram_read  <= 1'b0;
                        ram_write <= 1'b0;
                        if (!op_write) begin
                            if (gnt_m1) begin
                                m1_rdata <= ram_rdata;
                            end else begin
                                m0_rdata <= ram_rdata;
                            end
                        end
                        m0_ready <= ~gnt_m1;
                        m1_ready <= gnt_m1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    m0_ready  <= 1'b0;
                    m1_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
